// File: rtl/sw_rxbuf_pkg.sv
// Shared types and helpers for the single-flow software RX buffer.
package sw_rxbuf_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRecv    = 2'd1,
        StDiscard = 2'd2
    } rx_state_e;

    // FrameLink control signals are active low.
    localparam logic FlAsserted   = 1'b0;
    localparam logic FlDeasserted = 1'b1;

    // Ceiling log2; log2(1) = 0.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sw_rxbuf_len_fifo.sv
// First-word-fall-through FIFO holding the byte lengths of committed frames.
module sw_rxbuf_len_fifo
    import sw_rxbuf_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic [log2(DEPTH):0] count
);

    localparam int unsigned IW = log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wr_idx_q, rd_idx_q;
    logic [IW:0]      count_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && (count_q != (IW+1)'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    // Index and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_idx_q <= wr_idx_q + 1'b1;
            if (pop_ok)  rd_idx_q <= rd_idx_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset since dout is gated by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_idx_q] <= din;
    end

    assign dout  = (count_q != '0) ? mem[rd_idx_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/sw_rxbuf_flow.sv
// Single-flow RX buffer: FrameLink frames into a circular RAM, read by software per frame.
module sw_rxbuf_flow
    import sw_rxbuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BLOCK_SIZE = 512,
    parameter int unsigned MAX_FRAMES = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           rx_data,
    input  logic [log2(DATA_WIDTH/8)-1:0]   rx_rem,
    input  logic                            rx_sof_n,
    input  logic                            rx_eof_n,
    input  logic                            rx_src_rdy_n,
    output logic                            rx_dst_rdy_n,
    input  logic [log2(BLOCK_SIZE)-1:0]     rd_addr,
    input  logic                            rd_req,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_vld,
    output logic                            frame_rdy,
    output logic [LEN_WIDTH-1:0]            frame_len,
    input  logic                            frame_done,
    output logic [log2(MAX_FRAMES):0]       frame_cnt,
    output logic                            drop
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned BW    = log2(BYTES);
    localparam int unsigned AW    = log2(BLOCK_SIZE);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CW    = log2(MAX_FRAMES) + 1;

    rx_state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] used, words_before, pop_words;
    logic [LEN_WIDTH-1:0] commit_len;
    logic [LEN_WIDTH:0]   len_round;
    logic space_full, fifo_full, accept, sof, eof;
    logic ram_we, commit, pop, drop_d;

    logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [AW-1:0]         rd_word_addr;
    logic                  rd_fire, rd_vld1_q;

    assign used       = wr_ptr_q - rd_ptr_q;
    assign space_full = (used == PW'(BLOCK_SIZE));
    assign fifo_full  = (frame_cnt == CW'(MAX_FRAMES));
    // Registers only (plus reset); the discard sink never stalls.
    assign rx_dst_rdy_n = reset | ((state_q != StDiscard) & (space_full | fifo_full));

    assign accept = (rx_src_rdy_n == FlAsserted) && !rx_dst_rdy_n;
    assign sof    = (rx_sof_n == FlAsserted);
    assign eof    = (rx_eof_n == FlAsserted);

    // In IDLE wr_ptr equals commit_ptr, so the same formula covers single-word frames.
    assign words_before = wr_ptr_q - commit_ptr_q;
    assign commit_len   = (LEN_WIDTH'(words_before) << BW) + LEN_WIDTH'(rx_rem) + LEN_WIDTH'(1);

    assign frame_rdy = (frame_cnt != '0);
    assign pop       = frame_done && frame_rdy;
    assign len_round = {1'b0, frame_len} + (LEN_WIDTH+1)'(BYTES - 1);
    assign pop_words = PW'(len_round >> BW);
    assign rd_ptr_d  = pop ? rd_ptr_q + pop_words : rd_ptr_q;

    // Receive FSM and write-side pointer next state.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ram_we       = 1'b0;
        commit       = 1'b0;
        drop_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && sof) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (eof) begin
                        commit       = 1'b1;
                        commit_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                if (accept) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (eof) begin
                        commit       = 1'b1;
                        commit_ptr_d = wr_ptr_q + 1'b1;
                        state_d      = StIdle;
                    end
                end else if (space_full && (frame_cnt == '0)) begin
                    // Frame can never fit: roll back to the last commit and sink the rest.
                    wr_ptr_d = commit_ptr_q;
                    state_d  = StDiscard;
                end
            end
            StDiscard: begin
                if (accept && eof) begin
                    drop_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop         <= drop_d;
        end
    end

    sw_rxbuf_len_fifo #(
        .WIDTH(LEN_WIDTH),
        .DEPTH(MAX_FRAMES)
    ) u_len_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (commit),
        .din   (commit_len),
        .pop   (pop),
        .dout  (frame_len),
        .count (frame_cnt)
    );

    assign rd_word_addr = rd_ptr_q[AW-1:0] + rd_addr;
    assign rd_fire      = rd_req && frame_rdy;

    // Data RAM: one write port, registered read port.
    always_ff @(posedge clk) begin
        if (ram_we)  mem[wr_ptr_q[AW-1:0]] <= rx_data;
        if (rd_fire) ram_q <= mem[rd_word_addr];
    end

    // Read pipeline valid tracking and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld1_q <= 1'b0;
            rd_vld    <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_vld1_q <= rd_fire;
            rd_vld    <= rd_vld1_q;
            if (rd_vld1_q) rd_data <= ram_q;
        end
    end

endmodule

// File: tb/tb_sw_rxbuf_flow.sv
// Directed self-checking bench for sw_rxbuf_flow (64-bit, 16-word ring, 4 frames).
module tb_sw_rxbuf_flow;

    localparam int unsigned DW = 64;
    localparam int unsigned BS = 16;
    localparam int unsigned MF = 4;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic [2:0]    rx_rem = '0;
    logic          rx_sof_n = 1'b1, rx_eof_n = 1'b1, rx_src_rdy_n = 1'b1;
    logic          rx_dst_rdy_n;
    logic [3:0]    rd_addr = '0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_vld, frame_rdy, frame_done = 1'b0, drop;
    logic [LW-1:0] frame_len;
    logic [2:0]    frame_cnt;

    int tests = 0;
    int fails = 0;

    sw_rxbuf_flow #(
        .DATA_WIDTH(DW),
        .BLOCK_SIZE(BS),
        .MAX_FRAMES(MF),
        .LEN_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_rem       (rx_rem),
        .rx_sof_n     (rx_sof_n),
        .rx_eof_n     (rx_eof_n),
        .rx_src_rdy_n (rx_src_rdy_n),
        .rx_dst_rdy_n (rx_dst_rdy_n),
        .rd_addr      (rd_addr),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_vld       (rd_vld),
        .frame_rdy    (frame_rdy),
        .frame_len    (frame_len),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wv(input int fid, input int j);
        return 64'hA500_0000_0000_0000 | (64'(fid) << 8) | 64'(j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic sof, input logic eof,
                             input logic [2:0] rem);
        int budget;
        budget = 0;
        rx_data = d;
        rx_sof_n = ~sof;
        rx_eof_n = ~eof;
        rx_rem = rem;
        rx_src_rdy_n = 1'b0;
        while (rx_dst_rdy_n && budget < 100) begin
            tick();
            budget++;
        end
        if (budget >= 100) check("accept_timeout", 64'(rx_dst_rdy_n), 64'd0);
        tick();
        rx_src_rdy_n = 1'b1;
        rx_sof_n = 1'b1;
        rx_eof_n = 1'b1;
    endtask

    task automatic send_frame(input int fid, input int n, input logic [2:0] rem);
        for (int j = 0; j < n; j++) send_word(wv(fid, j), j == 0, j == n - 1, rem);
    endtask

    // Back-to-back reads of words 0..n-1 of the head frame.
    task automatic read_burst(input int fid, input int n);
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                rd_req = 1'b1;
                rd_addr = 4'(k);
            end else begin
                rd_req = 1'b0;
            end
            tick();
            if (k >= 1) begin
                check("rd_vld", 64'(rd_vld), 64'd1);
                check("rd_data", rd_data, wv(fid, k - 1));
            end
        end
        tick();
        check("rd_vld_drain", 64'(rd_vld), 64'd0);
    endtask

    task automatic done_pulse();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_dst_rdy_n", 64'(rx_dst_rdy_n), 64'd1);
        check("rst_rd_vld", 64'(rd_vld), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_frame_rdy", 64'(frame_rdy), 64'd0);
        check("rst_frame_len", 64'(frame_len), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_dst_rdy_n", 64'(rx_dst_rdy_n), 64'd0);

        // 3-word frame, rem 3: 2*8+4 = 20 bytes.
        send_frame(1, 3, 3'd3);
        check("t1_frame_rdy", 64'(frame_rdy), 64'd1);
        check("t1_frame_len", 64'(frame_len), 64'd20);
        check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        read_burst(1, 3);

        // Second frame: 8+8 = 16 bytes; release heads in order.
        send_frame(2, 2, 3'd7);
        check("t2_cnt2", 64'(frame_cnt), 64'd2);
        check("t2_len_head", 64'(frame_len), 64'd20);
        done_pulse();
        check("t2_len_after_done", 64'(frame_len), 64'd16);
        check("t2_cnt1", 64'(frame_cnt), 64'd1);
        read_burst(2, 2);
        done_pulse();
        check("t2_rdy_empty", 64'(frame_rdy), 64'd0);
        check("t2_cnt0", 64'(frame_cnt), 64'd0);
        rd_req = 1'b1;
        rd_addr = 4'd0;
        tick();
        rd_req = 1'b0;
        tick();
        check("t2_rd_ignored", 64'(rd_vld), 64'd0);

        // Full ring: two 8-word frames, third stalls until a release; wraps to offset 0.
        apply_reset();
        send_frame(3, 8, 3'd7);
        send_frame(4, 8, 3'd7);
        check("t3_cnt2", 64'(frame_cnt), 64'd2);
        check("t3_len64", 64'(frame_len), 64'd64);
        check("t3_full_stall", 64'(rx_dst_rdy_n), 64'd1);
        rx_data = wv(5, 0);
        rx_sof_n = 1'b0;
        rx_eof_n = 1'b0;
        rx_rem = 3'd0;
        rx_src_rdy_n = 1'b0;
        repeat (3) tick();
        check("t3_still_stalled", 64'(rx_dst_rdy_n), 64'd1);
        check("t3_cnt_stalled", 64'(frame_cnt), 64'd2);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("t3_space_freed", 64'(rx_dst_rdy_n), 64'd0);
        check("t3_cnt_after_done", 64'(frame_cnt), 64'd1);
        tick();
        rx_src_rdy_n = 1'b1;
        rx_sof_n = 1'b1;
        rx_eof_n = 1'b1;
        check("t3_wrap_commit", 64'(frame_cnt), 64'd2);
        done_pulse();
        check("t3_wrap_len", 64'(frame_len), 64'd1);
        read_burst(5, 1);
        done_pulse();
        check("t3_empty", 64'(frame_cnt), 64'd0);

        // Oversize 20-word frame into empty ring is dropped.
        for (int j = 0; j < 20; j++) begin
            send_word(wv(6, j), j == 0, j == 19, 3'd0);
            if (j == 18) check("t4_no_early_drop", 64'(drop), 64'd0);
        end
        check("t4_drop", 64'(drop), 64'd1);
        check("t4_cnt0", 64'(frame_cnt), 64'd0);
        check("t4_rdy0", 64'(frame_rdy), 64'd0);
        tick();
        check("t4_drop_pulse", 64'(drop), 64'd0);
        send_frame(7, 2, 3'd5);
        check("t4_cnt1", 64'(frame_cnt), 64'd1);
        check("t4_len14", 64'(frame_len), 64'd14);
        read_burst(7, 2);
        done_pulse();

        // Length FIFO full: fifth frame stalls; EOF with DONE keeps the count.
        for (int k = 0; k < 4; k++) send_frame(10 + k, 1, 3'(k));
        check("t5_cnt4", 64'(frame_cnt), 64'd4);
        check("t5_fifo_stall", 64'(rx_dst_rdy_n), 64'd1);
        check("t5_len1", 64'(frame_len), 64'd1);
        rx_data = wv(14, 0);
        rx_sof_n = 1'b0;
        rx_eof_n = 1'b0;
        rx_rem = 3'd4;
        rx_src_rdy_n = 1'b0;
        repeat (2) tick();
        check("t5_still_stalled", 64'(rx_dst_rdy_n), 64'd1);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("t5_cnt3", 64'(frame_cnt), 64'd3);
        check("t5_resume", 64'(rx_dst_rdy_n), 64'd0);
        check("t5_len2", 64'(frame_len), 64'd2);
        tick();
        rx_src_rdy_n = 1'b1;
        check("t5_cnt_refill", 64'(frame_cnt), 64'd4);
        done_pulse();
        check("t5_len3", 64'(frame_len), 64'd3);
        rx_data = wv(15, 0);
        rx_rem = 3'd5;
        rx_src_rdy_n = 1'b0;
        frame_done = 1'b1;
        tick();
        rx_src_rdy_n = 1'b1;
        rx_sof_n = 1'b1;
        rx_eof_n = 1'b1;
        frame_done = 1'b0;
        check("t5_eof_done_same", 64'(frame_cnt), 64'd3);
        check("t5_len4", 64'(frame_len), 64'd4);
        read_burst(13, 1);

        // Reset in the middle of a frame with one committed frame and a read in flight.
        done_pulse();
        done_pulse();
        check("t6_cnt1", 64'(frame_cnt), 64'd1);
        send_word(wv(16, 0), 1'b1, 1'b0, 3'd0);
        send_word(wv(16, 1), 1'b0, 1'b0, 3'd0);
        rd_req = 1'b1;
        rd_addr = 4'd0;
        tick();
        rd_req = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_rd_vld", 64'(rd_vld), 64'd0);
        check("t6_rd_data", rd_data, 64'd0);
        check("t6_frame_rdy", 64'(frame_rdy), 64'd0);
        check("t6_frame_len", 64'(frame_len), 64'd0);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t6_dst_rdy_n", 64'(rx_dst_rdy_n), 64'd1);
        tick();
        tick();
        check("t6_rd_vld_held", 64'(rd_vld), 64'd0);
        reset = 1'b0;
        #1;
        check("t6_dst_rdy_after", 64'(rx_dst_rdy_n), 64'd0);
        send_frame(17, 3, 3'd2);
        check("t6_cnt_new", 64'(frame_cnt), 64'd1);
        check("t6_len19", 64'(frame_len), 64'd19);
        read_burst(17, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
